// File: rtl/pong_graphics_pkg.sv
// Shared constants and types for the Pong video pipeline: raster size,
// object sizes, RGB332 palette and the packed coordinate type.
package pong_graphics_pkg;

    // Visible raster
    localparam int DEF_WIDTH     = 620;
    localparam int DEF_HEIGHT    = 420;

    // Object sizes
    localparam int DEF_PADDLE_W  = 10;
    localparam int DEF_PADDLE_H  = 60;
    localparam int DEF_BALL_SIZE = 8;

    // RGB332 palette
    localparam logic [7:0] COL_BG     = 8'h00;
    localparam logic [7:0] COL_BALL   = 8'hE0;
    localparam logic [7:0] COL_PADDLE = 8'hFF;
    localparam logic [7:0] COL_NET    = 8'h92;

    // Top-left corner of an object; x sits in the MSBs to match the port packing
    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
    } point_t;

    // Sign-extend a 16-bit coordinate so that adding an object size cannot wrap
    function automatic logic signed [16:0] sext17(input logic signed [15:0] v);
        return {v[15], v};
    endfunction

endpackage

// File: rtl/rect_hit.sv
// Combinational hit test of one pixel against an axis-aligned rectangle.
// Lower bounds inclusive, upper bounds exclusive; arithmetic is 17-bit
// signed so an origin near +32767 does not wrap around to negative.
module rect_hit
    import pong_graphics_pkg::*;
#(
    parameter int W = DEF_PADDLE_W,
    parameter int H = DEF_PADDLE_H
) (
    input  point_t             origin,
    input  logic signed [15:0] px,
    input  logic signed [15:0] py,
    output logic               hit
);

    localparam logic signed [16:0] W_S = 17'(W);
    localparam logic signed [16:0] H_S = 17'(H);

    logic signed [16:0] x_lo;
    logic signed [16:0] x_hi;
    logic signed [16:0] y_lo;
    logic signed [16:0] y_hi;
    logic signed [16:0] px_e;
    logic signed [16:0] py_e;
    logic               in_x;
    logic               in_y;

    // Rectangle span and containment of (px,py)
    always_comb begin
        x_lo = sext17(origin.x);
        y_lo = sext17(origin.y);
        x_hi = x_lo + W_S;
        y_hi = y_lo + H_S;
        px_e = sext17(px);
        py_e = sext17(py);
        in_x = (px_e >= x_lo) && (px_e < x_hi);
        in_y = (py_e >= y_lo) && (py_e < y_hi);
        hit  = in_x && in_y;
    end

endmodule

// File: rtl/pixel_generation_logic.sv
// Per-pixel colour generator: resolves ball, paddles, centre net and the
// visible-area clip for the raster coordinate (nextX,nextY) and registers
// the resulting RGB332 colour. One cycle of latency, one pixel per cycle.
module pixel_generation_logic
    import pong_graphics_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int HEIGHT    = DEF_HEIGHT,
    parameter int PADDLE_W  = DEF_PADDLE_W,
    parameter int PADDLE_H  = DEF_PADDLE_H,
    parameter int BALL_SIZE = DEF_BALL_SIZE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        leftPaddle,
    input  logic [31:0]        rightPaddle,
    input  logic [31:0]        pongBall,
    input  logic signed [15:0] nextX,
    input  logic signed [15:0] nextY,
    output logic [7:0]         pixelOut
);

    localparam logic signed [16:0] X_LIM  = 17'(WIDTH);
    localparam logic signed [16:0] Y_LIM  = 17'(HEIGHT);
    localparam logic signed [16:0] NET_X0 = 17'(WIDTH / 2 - 1);
    localparam logic signed [16:0] NET_X1 = 17'(WIDTH / 2);

    point_t left_pos;
    point_t right_pos;
    point_t ball_pos;

    logic hit_left;
    logic hit_right;
    logic hit_ball;

    logic signed [16:0] x_e;
    logic signed [16:0] y_e;
    logic               off_screen;
    logic               on_net;
    logic [7:0]         colour;

    assign left_pos  = point_t'(leftPaddle);
    assign right_pos = point_t'(rightPaddle);
    assign ball_pos  = point_t'(pongBall);

    rect_hit #(.W(PADDLE_W), .H(PADDLE_H)) u_hit_left (
        .origin (left_pos),
        .px     (nextX),
        .py     (nextY),
        .hit    (hit_left)
    );

    rect_hit #(.W(PADDLE_W), .H(PADDLE_H)) u_hit_right (
        .origin (right_pos),
        .px     (nextX),
        .py     (nextY),
        .hit    (hit_right)
    );

    rect_hit #(.W(BALL_SIZE), .H(BALL_SIZE)) u_hit_ball (
        .origin (ball_pos),
        .px     (nextX),
        .py     (nextY),
        .hit    (hit_ball)
    );

    // Visible-area clip and dashed centre net (8 rows on, 8 rows off)
    always_comb begin
        x_e        = sext17(nextX);
        y_e        = sext17(nextY);
        off_screen = (x_e < 17'sd0) || (x_e >= X_LIM) ||
                     (y_e < 17'sd0) || (y_e >= Y_LIM);
        on_net     = ((x_e == NET_X0) || (x_e == NET_X1)) && !nextY[3];
    end

    // Priority mux: clip, ball, paddles, net, background
    always_comb begin
        colour = COL_BG;
        if (off_screen) begin
            colour = COL_BG;
        end else if (hit_ball) begin
            colour = COL_BALL;
        end else if (hit_left || hit_right) begin
            colour = COL_PADDLE;
        end else if (on_net) begin
            colour = COL_NET;
        end
    end

    // Output register; reset clears only the colour
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixelOut <= COL_BG;
        end else begin
            pixelOut <= colour;
        end
    end

endmodule

// File: tb/tb_pixel_generation_logic.sv
// Bench for pixel_generation_logic: directed corner cases plus randomised
// raster sweeps checked against a behavioural colour model.
module tb_pixel_generation_logic;

    logic               clk;
    logic               clk_en;
    logic               rst_n;
    logic [31:0]        leftPaddle;
    logic [31:0]        rightPaddle;
    logic [31:0]        pongBall;
    logic signed [15:0] nextX;
    logic signed [15:0] nextY;
    logic [7:0]         pixelOut;

    int n_checks = 0;
    int n_fail   = 0;

    // Current object positions as plain integers for the model
    int lx, ly, rx, ry, bx, by;

    pixel_generation_logic dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .leftPaddle  (leftPaddle),
        .rightPaddle (rightPaddle),
        .pongBall    (pongBall),
        .nextX       (nextX),
        .nextY       (nextY),
        .pixelOut    (pixelOut)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int x, input int y);
        logic [15:0] hx;
        logic [15:0] hy;
        hx = 16'(x);
        hy = 16'(y);
        return {hx, hy};
    endfunction

    function automatic bit inside_rect(input int x, input int y, input int ox, input int oy,
                                       input int w, input int h);
        return (x >= ox) && (x < ox + w) && (y >= oy) && (y < oy + h);
    endfunction

    // Reference colour of a pixel from the game rules
    function automatic logic [7:0] ref_colour(input int x, input int y);
        if (x < 0 || x >= 620 || y < 0 || y >= 420) return 8'h00;
        if (inside_rect(x, y, bx, by, 8, 8)) return 8'hE0;
        if (inside_rect(x, y, lx, ly, 10, 60) || inside_rect(x, y, rx, ry, 10, 60)) return 8'hFF;
        if ((x == 309 || x == 310) && ((y / 8) % 2 == 0)) return 8'h92;
        return 8'h00;
    endfunction

    task automatic set_objects(input int l_x, input int l_y, input int r_x, input int r_y,
                               input int b_x, input int b_y);
        lx = l_x; ly = l_y; rx = r_x; ry = r_y; bx = b_x; by = b_y;
        leftPaddle  = pack(lx, ly);
        rightPaddle = pack(rx, ry);
        pongBall    = pack(bx, by);
    endtask

    // Present one pixel, clock it, compare against a fixed expectation
    task automatic pix(input string tag, input int x, input int y, input logic [7:0] exp);
        nextX = 16'(x);
        nextY = 16'(y);
        @(posedge clk);
        #1;
        check(tag, pixelOut, exp);
    endtask

    int rnd;

    initial begin
        clk_en = 1'b1;
        rst_n  = 1'b0;
        nextX  = '0;
        nextY  = '0;
        set_objects(10, 100, 600, 200, 300, 150);
        repeat (2) @(posedge clk);
        #1;
        check("reset_value", pixelOut, 8'h00);
        rst_n = 1'b1;

        // Async reset with the clock stopped
        pix("pre_reset_ball", 300, 150, 8'hE0);
        @(negedge clk);
        clk_en = 1'b0;
        #3 rst_n = 1'b0;
        #1 check("async_reset", pixelOut, 8'h00);
        #5 rst_n = 1'b1;
        #1 check("reset_hold_no_clk", pixelOut, 8'h00);
        clk_en = 1'b1;
        pix("post_reset_ball", 300, 150, 8'hE0);

        // Paddles
        pix("lpad_tl", 10, 100, 8'hFF);
        pix("lpad_br", 19, 159, 8'hFF);
        pix("lpad_right_excl", 20, 100, 8'h00);
        pix("lpad_bottom_excl", 10, 160, 8'h00);
        pix("rpad_tl", 600, 200, 8'hFF);
        pix("rpad_right_excl", 610, 200, 8'h00);

        // Ball edges and ball over paddle
        pix("ball_tl", 300, 150, 8'hE0);
        pix("ball_br", 307, 157, 8'hE0);
        pix("ball_right_excl", 308, 150, 8'h00);
        set_objects(10, 100, 600, 200, 12, 110);
        pix("ball_over_paddle", 12, 110, 8'hE0);
        set_objects(10, 100, 600, 200, 300, 150);

        // Net
        pix("net_309_0", 309, 0, 8'h92);
        pix("net_310_7", 310, 7, 8'h92);
        pix("net_gap_310_8", 310, 8, 8'h00);
        pix("net_col_311", 311, 0, 8'h00);
        set_objects(10, 100, 600, 200, 306, 0);
        pix("ball_over_net", 309, 0, 8'hE0);
        pix("ball_over_net2", 310, 0, 8'hE0);
        set_objects(10, 100, 600, 200, 300, 150);

        // Bounds and clipping
        pix("oob_left", -1, 50, 8'h00);
        pix("oob_right", 620, 50, 8'h00);
        pix("oob_top", 5, -1, 8'h00);
        pix("oob_bottom", 5, 420, 8'h00);
        set_objects(-5, 0, 600, 200, 300, 150);
        pix("clipped_paddle", 0, 0, 8'hFF);
        pix("clipped_paddle_edge", 5, 0, 8'h00);
        set_objects(10, 100, 600, 200, 32764, 0);
        pix("ball_no_wrap", 619, 0, 8'h00);
        set_objects(10, 100, 600, 200, 32764, 0);
        pix("ball_no_wrap_lo", 0, 0, 8'h00);
        set_objects(32765, 0, 600, 200, 300, 150);
        pix("paddle_no_wrap", 2, 0, 8'h00);

        // Randomised sweeps: every 10th row, all columns plus a margin each side
        for (int s = 0; s < 2; s++) begin
            int phase;
            set_objects(int'($urandom_range(0, 680)) - 40, int'($urandom_range(0, 520)) - 70,
                        int'($urandom_range(0, 680)) - 40, int'($urandom_range(0, 520)) - 70,
                        int'($urandom_range(0, 660)) - 20, int'($urandom_range(0, 460)) - 20);
            if (s == 1) begin
                // Pull objects onto the net / each other to exercise priority
                rnd = int'($urandom_range(0, 12));
                set_objects(300 + rnd, 40, 305, 60, 303 + rnd, 50);
            end
            phase = int'($urandom_range(0, 9));
            for (int y = phase; y < 420; y += 10) begin
                for (int x = -2; x < 622; x++) begin
                    nextX = 16'(x);
                    nextY = 16'(y);
                    @(posedge clk);
                    #1;
                    check("sweep", pixelOut, ref_colour(x, y));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
